// File: rtl/rowstream_arbiter.sv
// rowstream_arbiter: round-robin share of one 32-bit AXI-Stream master between Y/Cb/Cr row producers.
// Latency: row written on edge E is granted on E+1; beat 0 valid in the cycle after E+1; one idle cycle between rows.
// Backpressure: output stalls on m_axis_ready low; producers cannot be stalled, full FIFOs drop rows and set o_ovf.
// Optional feature macro: CHAN_TAG_EN (puts granted channel and beat index in m_axis_data[31:28]).
// i_rst asserts asynchronously; its release is expected to be synchronous to i_clk.
module rowstream_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_y_valid,
  input  logic [95:0] i_y_data,
  input  logic        i_cb_valid,
  input  logic [95:0] i_cb_data,
  input  logic        i_cr_valid,
  input  logic [95:0] i_cr_data,
  output logic [31:0] m_axis_data,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
  output logic        m_axis_last,
  output logic [2:0]  o_ovf,
  output logic        o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [1:0]  gch;
  logic [1:0]  last_ch;
  logic [1:0]  w;
  logic [95:0] row_q;
  logic [2:0]  row_cnt [3];

  logic [2:0]  wr_vld;
  logic [95:0] wr_dat [3];
  logic [95:0] mem [3][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [3];
  logic [PW-1:0] rd_ptr [3];
  logic [CW-1:0] cnt [3];
  logic [2:0]  push;
  logic [2:0]  pop;
  logic        hs;

  logic [1:0]  c1, c2, sel_ch;
  logic        sel_ok;
  logic [1:0]  ld_ch, ld_w;
  logic [95:0] ld_row;
  logic [31:0] beat_nxt;
  logic        last_nxt;

  assign wr_vld    = {i_cr_valid, i_cb_valid, i_y_valid};
  assign wr_dat[0] = i_y_data;
  assign wr_dat[1] = i_cb_data;
  assign wr_dat[2] = i_cr_data;
  assign hs        = m_axis_valid && m_axis_ready;

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // Accept/pop decisions; a full FIFO refuses a write even if it pops this cycle
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < 3; i++) begin
      push[i] = wr_vld[i] && (cnt[i] < CW'(FIFO_DEPTH));
      pop[i]  = hs && (state == SEND) && (w == 2'd3) && (gch == 2'(i));
    end
  end

  // Row storage (contents need no reset; counts define validity)
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= wr_dat[i];
    end
  end

  // FIFO pointers, occupancy counts and sticky overflow flags
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      o_ovf <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - CW'(1);
        if (wr_vld[i] && !push[i])   o_ovf[i] <= 1'b1;
      end
    end
  end

  // Round-robin pick, starting after the last granted channel
  always_comb begin
    c1     = next_ch(last_ch);
    c2     = next_ch(c1);
    sel_ok = 1'b1;
    if (cnt[c1] != '0)           sel_ch = c1;
    else if (cnt[c2] != '0)      sel_ch = c2;
    else if (cnt[last_ch] != '0) sel_ch = last_ch;
    else begin
      sel_ch = last_ch;
      sel_ok = 1'b0;
    end
  end

  // Next beat to present: beat 0 of the FIFO head in IDLE, otherwise beat w+1 of the held row
  always_comb begin
    ld_ch  = gch;
    ld_w   = w + 2'd1;
    ld_row = row_q;
    if (state == IDLE) begin
      ld_ch  = sel_ch;
      ld_w   = 2'd0;
      ld_row = mem[sel_ch][rd_ptr[sel_ch]];
    end
    beat_nxt        = '0;
    beat_nxt[23:12] = ld_row[int'(ld_w) * 24 +: 12];
    beat_nxt[11:0]  = ld_row[int'(ld_w) * 24 + 12 +: 12];
`ifdef CHAN_TAG_EN
    beat_nxt[31:30] = ld_ch;
    beat_nxt[29:28] = ld_w;
`endif
    last_nxt = (row_cnt[ld_ch] == 3'd7) && (ld_w == 2'd3);
  end

  // Grant/serialise FSM with registered AXI-Stream outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      gch          <= 2'd0;
      last_ch      <= 2'd2;
      w            <= 2'd0;
      row_q        <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
      for (int i = 0; i < 3; i++) row_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_ok) begin
            state        <= SEND;
            gch          <= sel_ch;
            last_ch      <= sel_ch;
            w            <= 2'd0;
            row_q        <= ld_row;
            m_axis_valid <= 1'b1;
            m_axis_data  <= beat_nxt;
            m_axis_last  <= last_nxt;
          end
        end
        SEND: begin
          if (hs) begin
            if (w == 2'd3) begin
              state        <= IDLE;
              w            <= 2'd0;
              m_axis_valid <= 1'b0;
              m_axis_data  <= '0;
              m_axis_last  <= 1'b0;
              row_cnt[gch] <= row_cnt[gch] + 3'd1;
            end else begin
              w           <= ld_w;
              m_axis_data <= beat_nxt;
              m_axis_last <= last_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy while a row is in flight or anything is queued
  always_comb begin
    o_busy = (state != IDLE) || (cnt[0] != '0) || (cnt[1] != '0) || (cnt[2] != '0);
  end

endmodule

// File: tb/tb_rowstream_arbiter.sv
// Directed bench for rowstream_arbiter with a beat scoreboard.
module tb_rowstream_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_y_valid = 1'b0, i_cb_valid = 1'b0, i_cr_valid = 1'b0;
  logic [95:0] i_y_data = '0, i_cb_data = '0, i_cr_data = '0;
  logic [31:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready = 1'b0;
  logic        m_axis_last;
  logic [2:0]  o_ovf;
  logic        o_busy;

  rowstream_arbiter #(.FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_y_valid(i_y_valid), .i_y_data(i_y_data),
    .i_cb_valid(i_cb_valid), .i_cb_data(i_cb_data),
    .i_cr_valid(i_cr_valid), .i_cr_data(i_cr_data),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last),
    .o_ovf(o_ovf), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic [32:0] q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          hs_cnt = 0;
  int          beat_idx = 0;
  int          lasts_seen = 0;
  int          gap_state = 0;
  bit          gap_chk = 1'b0;
  bit          hold_pending = 1'b0;
  logic [32:0] hold_val = '0;
  logic [2:0]  rc [3];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] mk_row(input int base);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[12*k +: 12] = 12'(base + k);
    return r;
  endfunction

  task automatic push_row(input int ch, input logic [95:0] row);
    logic [31:0] d;
    for (int bw = 0; bw < 4; bw++) begin
      d = '0;
      d[23:12] = row[24*bw +: 12];
      d[11:0]  = row[24*bw + 12 +: 12];
`ifdef CHAN_TAG_EN
      d[31:30] = 2'(ch);
      d[29:28] = 2'(bw);
`endif
      q.push_back({d, (rc[ch] == 3'd7) && (bw == 3)});
    end
    rc[ch] = rc[ch] + 3'd1;
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 3; i++) rc[i] = 3'd0;
    hold_pending = 1'b0;
    gap_state = 0;
    hs_cnt = 0;
    beat_idx = 0;
    lasts_seen = 0;
  endtask

  // Output checks made mid-cycle, before the edge that completes any handshake
  task automatic check_cycle();
    logic [32:0] e;
    if (hold_pending)
      chk("hold_stable", 96'({m_axis_valid, m_axis_data, m_axis_last}), 96'({1'b1, hold_val}));
    hold_pending = m_axis_valid && !m_axis_ready;
    hold_val = {m_axis_data, m_axis_last};
    if (gap_chk && gap_state == 1) begin
      chk("gap_valid_low", 96'(m_axis_valid), 96'(0));
      gap_state = (q.size() != 0) ? 2 : 0;
    end else if (gap_chk && gap_state == 2) begin
      chk("gap_resume", 96'(m_axis_valid), 96'(1));
      gap_state = 0;
    end
    if (m_axis_valid && m_axis_ready) begin
      hs_cnt++;
      beat_idx++;
      if (m_axis_last) lasts_seen++;
      chk("beat_expected", 96'(q.size() != 0), 96'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("beat", 96'({m_axis_data, m_axis_last}), 96'(e));
      end
      if (beat_idx % 4 == 0) gap_state = 1;
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
    check_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (q.size() == 0 && !m_axis_valid && !o_busy) break;
      cyc();
    end
    chk("drain_q_empty", 96'(q.size()), 96'(0));
    chk("drain_idle", 96'({m_axis_valid, o_busy}), 96'(0));
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    i_y_valid = 1'b0; i_cb_valid = 1'b0; i_cr_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    clear_model();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rc[i] = 3'd0;
    #1;
    chk("rst_valid", 96'(m_axis_valid), 96'(0));
    chk("rst_data",  96'(m_axis_data),  96'(0));
    chk("rst_last",  96'(m_axis_last),  96'(0));
    chk("rst_ovf",   96'(o_ovf),        96'(0));
    chk("rst_busy",  96'(o_busy),       96'(0));
    do_reset();

    // Single Y row with latency checks
    m_axis_ready = 1'b1;
    i_y_data = mk_row(1);
    i_y_valid = 1'b1;
    push_row(0, i_y_data);
    cyc();
    i_y_valid = 1'b0;
    chk("lat_after_write", 96'(m_axis_valid), 96'(0));
    chk("busy_after_write", 96'(o_busy), 96'(1));
    cyc();
    chk("lat_granted", 96'(m_axis_valid), 96'(1));
    chk("beat0_samples", 96'(m_axis_data[23:0]), 96'(24'h001002));
    drain(40);
    chk("t1_handshakes", 96'(hs_cnt), 96'(4));

    // Three channels written together: Y, Cb, Cr with one-cycle gaps
    do_reset();
    m_axis_ready = 1'b1;
    gap_chk = 1'b1;
    i_y_data = mk_row(16'h010); i_cb_data = mk_row(16'h020); i_cr_data = mk_row(16'h030);
    i_y_valid = 1'b1; i_cb_valid = 1'b1; i_cr_valid = 1'b1;
    push_row(0, i_y_data); push_row(1, i_cb_data); push_row(2, i_cr_data);
    cyc();
    i_y_valid = 1'b0; i_cb_valid = 1'b0; i_cr_valid = 1'b0;
    drain(60);
    chk("t2_handshakes", 96'(hs_cnt), 96'(12));
    gap_chk = 1'b0;

    // Backpressure: ready 1,0,0,1 inside a row
    do_reset();
    m_axis_ready = 1'b1;
    i_cr_data = mk_row(16'h0A0);
    i_cr_valid = 1'b1;
    push_row(2, i_cr_data);
    cyc();
    i_cr_valid = 1'b0;
    cyc();
    chk("bp_valid_up", 96'(m_axis_valid), 96'(1));
    m_axis_ready = 1'b1; cyc();
    m_axis_ready = 1'b0; cyc();
    m_axis_ready = 1'b0; cyc();
    chk("bp_valid_held", 96'(m_axis_valid), 96'(1));
    m_axis_ready = 1'b1;
    drain(40);
    chk("bp_handshakes", 96'(hs_cnt), 96'(4));

    // Block boundary: nine Cr rows, last only on row 8 beat 3
    do_reset();
    m_axis_ready = 1'b1;
    for (int r = 0; r < 9; r++) begin
      i_cr_data = mk_row(16 * r + 3);
      i_cr_valid = 1'b1;
      push_row(2, i_cr_data);
      cyc();
      i_cr_valid = 1'b0;
      repeat (4) cyc();
    end
    drain(80);
    chk("blk_last_count", 96'(lasts_seen), 96'(1));
    chk("blk_ovf", 96'(o_ovf), 96'(0));
    chk("blk_handshakes", 96'(hs_cnt), 96'(36));

    // Overflow: five Cb rows with the sink stalled
    do_reset();
    m_axis_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      i_cb_data = mk_row(16'h200 + 16 * r);
      i_cb_valid = 1'b1;
      if (r < 4) push_row(1, i_cb_data);
      cyc();
    end
    i_cb_valid = 1'b0;
    cyc();
    chk("ovf_flag", 96'(o_ovf), 96'(3'b010));
    chk("ovf_valid_stalled", 96'(m_axis_valid), 96'(1));
    m_axis_ready = 1'b1;
    drain(80);
    chk("ovf_handshakes", 96'(hs_cnt), 96'(16));
    chk("ovf_sticky", 96'(o_ovf), 96'(3'b010));

    // Reset during beat 2 of a row
    hs_cnt = 0;
    m_axis_ready = 1'b1;
    i_y_data = mk_row(16'h100);
    i_y_valid = 1'b1;
    push_row(0, i_y_data);
    cyc();
    i_y_valid = 1'b0;
    for (int n = 0; n < 20 && hs_cnt < 2; n++) cyc();
    chk("rst_mid_reached_beat2", 96'(hs_cnt), 96'(2));
    #2;
    i_rst = 1'b0;
    #1;
    chk("rst_mid_valid", 96'(m_axis_valid), 96'(0));
    chk("rst_mid_data",  96'(m_axis_data),  96'(0));
    chk("rst_mid_last",  96'(m_axis_last),  96'(0));
    chk("rst_mid_ovf",   96'(o_ovf),        96'(0));
    chk("rst_mid_busy",  96'(o_busy),       96'(0));
    clear_model();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    repeat (20) cyc();
    chk("rst_no_residual", 96'(hs_cnt), 96'(0));
    chk("rst_idle_busy", 96'(o_busy), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
